// File: rtl/ad_bus_master_seq.sv
// Single-word AD bus sequencer: address, write data or turnaround/wait/capture, one-cycle response.
// Latency: write 4+waits cycles, read 4+TURN_CYCLES+waits cycles from accept; req_ready only in IDLE with Gnt.
module ad_bus_master_seq #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Gnt,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        Drive,
  output logic        OK,
  output logic [31:0] ADOut,
  output logic        AddrStb,
  input  logic        TRdy,
  input  logic [31:0] IPad,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] TURN  = 3'd3;
  localparam logic [2:0] RWAIT = 3'd4;
  localparam logic [2:0] RCAP  = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] TURN_C    = 8'(TURN_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        drive_q, drive_d;
  logic        ok_q;
  logic [31:0] adout_q, adout_d;
  logic        addrstb_q, addrstb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    adout_d     = adout_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = ADDR;
          write_d = req_write;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          adout_d = req_addr;
        end
      end
      ADDR: begin
        cnt_d = '0;
        if (write_q) begin
          state_d = WDATA;
          adout_d = wdata_q;
        end else begin
          state_d = TURN;
        end
      end
      WDATA: begin
        // TRdy wins over a timeout landing in the same cycle
        cnt_d = cnt_q + 8'd1;
        if (TRdy) begin
          state_d = DRAIN;
        end else if (cnt_d == TIMEOUT_C) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end
      end
      TURN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TURN_C) begin
          state_d = RWAIT;
          cnt_d   = '0;
        end
      end
      RWAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (TRdy) begin
          state_d = RCAP;
        end else if (cnt_d == TIMEOUT_C) begin
          state_d   = DONE;
          rsp_err_d = 1'b1;
        end
      end
      RCAP: begin
        // pad stage registers the bus, so read data appears one cycle after TRdy
        state_d     = DONE;
        rsp_rdata_d = IPad;
      end
      DRAIN: begin
        state_d   = DONE;
        rsp_err_d = err_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DONE) begin
      adout_d = '0;
    end
  end

  assign req_ready_d = (state_d == IDLE) && Gnt;
  assign drive_d     = (state_d == ADDR) || (state_d == WDATA);
  assign addrstb_d   = (state_q == ADDR);
  assign rsp_valid_d = (state_d == DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      drive_q     <= 1'b0;
      ok_q        <= 1'b0;
      adout_q     <= '0;
      addrstb_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      drive_q     <= drive_d;
      ok_q        <= Gnt;
      adout_q     <= adout_d;
      addrstb_q   <= addrstb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign Drive     = drive_q;
  assign OK        = ok_q;
  assign ADOut     = adout_q;
  assign AddrStb   = addrstb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ad_bus_master_seq.sv
// Bench for ad_bus_master_seq: per-transaction cycle-offset model derived from the protocol timing.
module tb_ad_bus_master_seq;

  localparam int TURN = 2;
  localparam int TO   = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Gnt;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        Drive;
  logic        OK;
  logic [31:0] ADOut;
  logic        AddrStb;
  logic        TRdy;
  logic [31:0] IPad;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int n_pass  = 0;
  int n_total = 0;

  ad_bus_master_seq #(.TURN_CYCLES(TURN), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Gnt(Gnt),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .Drive(Drive), .OK(OK), .ADOut(ADOut), .AddrStb(AddrStb),
    .TRdy(TRdy), .IPad(IPad),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
  );

  always #5 Clk = ~Clk;

  // One transaction; cycle 0 is the accept cycle. w = wait cycles before TRdy (w >= TO never raises TRdy).
  // gdrop > 0 drops Gnt from that cycle on. Returns with time at 1 unit after the edge starting cycle done+1.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic [31:0] data, input int gdrop, output int acc_wait);
    int n, done, trdy_c;
    bit err;
    logic drive_e, stb_e, valid_e, rr_e, ok_e;
    logic [31:0] adout_e, rdata_e;
    n   = (w < TO) ? w + 1 : TO;
    err = (w >= TO);
    if (wr) begin
      done   = 3 + n;
      trdy_c = 2 + w;
    end else begin
      done   = err ? 2 + TURN + n : 3 + TURN + n;
      trdy_c = 2 + TURN + w;
    end
    rdata_e   = (wr || err) ? 32'h0 : data;
    Gnt       = 1'b1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    TRdy      = 1'b0;
    IPad      = $urandom;
    acc_wait  = 0;
    while (req_ready !== 1'b1 && acc_wait < 20) begin
      @(posedge Clk); #1;
      acc_wait++;
    end
    n_total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL accept: req_ready=%b never reached required 1", req_ready);
      req_valid = 1'b0;
      return;
    end else n_pass++;
    for (int c = 1; c <= done + 1; c++) begin
      @(posedge Clk); #1;
      req_valid = 1'b0;
      if (wr) begin
        drive_e = (c >= 1 && c <= 1 + n);
        adout_e = (c == 1) ? addr : ((c < done) ? wdata : 32'h0);
      end else begin
        drive_e = (c == 1);
        adout_e = (c < done) ? addr : 32'h0;
      end
      stb_e   = (c == 2);
      valid_e = (c == done);
      rr_e    = (c == done + 1) ? Gnt : 1'b0;
      ok_e    = Gnt;
      n_total++;
      if (Drive !== drive_e) $display("FAIL drive c=%0d: got %b want %b", c, Drive, drive_e);
      else n_pass++;
      n_total++;
      if (ADOut !== adout_e) $display("FAIL adout c=%0d: got %h want %h", c, ADOut, adout_e);
      else n_pass++;
      n_total++;
      if (AddrStb !== stb_e) $display("FAIL addrstb c=%0d: got %b want %b", c, AddrStb, stb_e);
      else n_pass++;
      n_total++;
      if (rsp_valid !== valid_e) $display("FAIL rsp_valid c=%0d: got %b want %b", c, rsp_valid, valid_e);
      else n_pass++;
      n_total++;
      if (req_ready !== rr_e) $display("FAIL req_ready c=%0d: got %b want %b", c, req_ready, rr_e);
      else n_pass++;
      n_total++;
      if (OK !== ok_e) $display("FAIL ok c=%0d: got %b want %b", c, OK, ok_e);
      else n_pass++;
      if (c == done) begin
        n_total++;
        if (rsp_err !== err) $display("FAIL rsp_err c=%0d: got %b want %b", c, rsp_err, err);
        else n_pass++;
        n_total++;
        if (rsp_rdata !== rdata_e) $display("FAIL rsp_rdata c=%0d: got %h want %h", c, rsp_rdata, rdata_e);
        else n_pass++;
      end
      if (c == gdrop) Gnt = 1'b0;
      TRdy = (!err && c == trdy_c);
      IPad = (!err && !wr && c == trdy_c + 1) ? data : $urandom;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Gnt = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; TRdy = 1'b0; IPad = '0;
    repeat (3) @(posedge Clk);
    #1;
    n_total++;
    if ({req_ready, Drive, OK, AddrStb, rsp_valid, rsp_err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {req_ready, Drive, OK, AddrStb, rsp_valid, rsp_err});
    else n_pass++;
    n_total++;
    if ({ADOut, rsp_rdata} !== 64'h0) $display("FAIL reset_data: got %h want 0", {ADOut, rsp_rdata});
    else n_pass++;
    Gnt = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    n_total++;
    if ({req_ready, OK} !== 2'b00) $display("FAIL post_reset: got %b want 00", {req_ready, OK});
    else n_pass++;
  endtask

  task automatic test_gnt_gate();
    int aw;
    Gnt = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h55; req_wdata = 32'h66;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      n_total++;
      if ({req_ready, OK, Drive, AddrStb} !== 4'b0000)
        $display("FAIL gnt_low: got %b want 0000", {req_ready, OK, Drive, AddrStb});
      else n_pass++;
    end
    Gnt = 1'b1;
    @(posedge Clk); #1;
    n_total++;
    if ({req_ready, OK} !== 2'b11) $display("FAIL gnt_rise: got %b want 11", {req_ready, OK});
    else n_pass++;
    run_txn(1'b1, 32'h55, 32'h66, 1, 32'h0, -1, aw);
    n_total++;
    if (aw !== 0) $display("FAIL gnt_accept_wait: got %0d want 0", aw);
    else n_pass++;
  endtask

  task automatic test_write();
    int aw;
    run_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, -1, aw);
  endtask

  task automatic test_read();
    int aw;
    run_txn(1'b0, 32'h0000_2000, 32'h0, 3, 32'h1234_5678, -1, aw);
  endtask

  task automatic test_read_timeout();
    int aw;
    run_txn(1'b0, 32'h0000_3000, 32'h0, TO + 1, 32'hFFFF_FFFF, -1, aw);
  endtask

  task automatic test_write_timeout();
    int aw;
    run_txn(1'b1, 32'h0000_4000, 32'hCAFE_F00D, TO + 3, 32'h0, -1, aw);
  endtask

  task automatic test_back_to_back();
    int aw;
    run_txn(1'b1, 32'hA000_0000, 32'h1111_1111, 0, 32'h0, -1, aw);
    run_txn(1'b1, 32'hA000_0004, 32'h2222_2222, 1, 32'h0, -1, aw);
    n_total++;
    if (aw !== 0) $display("FAIL b2b_accept_wait: got %0d want 0", aw);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    Gnt = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hB0; req_wdata = 32'hB1; TRdy = 1'b0;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(posedge Clk); #1;
      k++;
    end
    repeat (2) begin
      @(posedge Clk); #1;
      req_valid = 1'b0;
    end
    n_total++;
    if (Drive !== 1'b1) $display("FAIL mid_pre_drive: got %b want 1", Drive);
    else n_pass++;
    #2 Reset = 1'b0;
    #1;
    n_total++;
    if ({Drive, OK, rsp_valid, req_ready} !== 4'b0000)
      $display("FAIL mid_reset_ctrl: got %b want 0000", {Drive, OK, rsp_valid, req_ready});
    else n_pass++;
    n_total++;
    if (ADOut !== 32'h0) $display("FAIL mid_reset_adout: got %h want 0", ADOut);
    else n_pass++;
    @(posedge Clk); #1;
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      n_total++;
      if ({rsp_valid, Drive} !== 2'b00) $display("FAIL mid_after: got %b want 00", {rsp_valid, Drive});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int aw, w, gd, exp_aw;
    bit wr;
    logic [31:0] a, d, r;
    exp_aw = 0;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      r  = $urandom;
      w  = int'($urandom_range(0, 5));
      gd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_txn(wr, a, d, w, r, gd, aw);
      n_total++;
      if (aw !== exp_aw) $display("FAIL rand_accept_wait t=%0d: got %0d want %0d", t, aw, exp_aw);
      else n_pass++;
      exp_aw = (gd > 0) ? 1 : 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_gnt_gate();
    test_write();
    test_read();
    test_read_timeout();
    test_write_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
